// File: rtl/signed_arith_unit.sv
// Multi-cycle signed/unsigned arithmetic unit: bit-serial shifts, compare, negate,
// absolute value and saturating add behind a valid/ready command/result handshake.
module signed_arith_unit #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         in_op,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic [SHAMT_W-1:0] in_shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_result,
    output logic               out_flag
);

    localparam logic [2:0] OP_SHR = 3'd0;
    localparam logic [2:0] OP_SHL = 3'd1;
    localparam logic [2:0] OP_CMP = 3'd2;
    localparam logic [2:0] OP_NEG = 3'd3;
    localparam logic [2:0] OP_ABS = 3'd4;
    localparam logic [2:0] OP_ADD = 3'd5;

    localparam logic [WIDTH-1:0]   S_MIN   = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0]   S_MAX   = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [SHAMT_W-1:0] SH_MAX  = SHAMT_W'(WIDTH);
    localparam logic [SHAMT_W-1:0] SH_ONE  = SHAMT_W'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t               state_q;
    logic                 in_ready_q;
    logic                 out_valid_q;
    logic [WIDTH-1:0]     res_q;
    logic                 flag_q;
    logic [SHAMT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]     work_q;
    logic                 sticky_q;
    logic                 sgn_q;
    logic                 shl_q;

    logic [WIDTH-1:0]     alu_res;
    logic                 alu_flag;
    logic                 gt;
    logic [WIDTH:0]       sum_ext;
    logic [WIDTH-1:0]     neg_a;
    logic [SHAMT_W-1:0]   shamt_clamped;
    logic                 is_shift;
    logic [WIDTH-1:0]     step_val;
    logic                 step_flag;

    assign in_ready   = in_ready_q;
    assign out_valid  = out_valid_q;
    assign out_result = res_q;
    assign out_flag   = flag_q;

    assign sum_ext       = {1'b0, in_a} + {1'b0, in_b};
    assign neg_a         = '0 - in_a;
    assign shamt_clamped = (in_shamt > SH_MAX) ? SH_MAX : in_shamt;
    assign is_shift      = (in_op == OP_SHR) || (in_op == OP_SHL);
    assign gt            = in_signed ? ($signed(in_a) > $signed(in_b)) : (in_a > in_b);

    // Single-cycle ops, evaluated on the command inputs at the accept edge
    always_comb begin
        alu_res  = '0;
        alu_flag = 1'b0;
        case (in_op)
            OP_SHR, OP_SHL: alu_res = in_a;
            OP_CMP: begin
                alu_flag = gt;
                alu_res  = {{(WIDTH-1){1'b0}}, gt};
            end
            OP_NEG: begin
                if (in_signed && (in_a == S_MIN)) begin
                    alu_res  = S_MAX;
                    alu_flag = 1'b1;
                end else begin
                    alu_res  = neg_a;
                    alu_flag = !in_signed && (in_a != '0);
                end
            end
            OP_ABS: begin
                if (!in_signed || !in_a[WIDTH-1]) begin
                    alu_res = in_a;
                end else if (in_a == S_MIN) begin
                    alu_res  = S_MAX;
                    alu_flag = 1'b1;
                end else begin
                    alu_res = neg_a;
                end
            end
            OP_ADD: begin
                if (in_signed) begin
                    if ((in_a[WIDTH-1] == in_b[WIDTH-1]) &&
                        (sum_ext[WIDTH-1] != in_a[WIDTH-1])) begin
                        alu_res  = in_a[WIDTH-1] ? S_MIN : S_MAX;
                        alu_flag = 1'b1;
                    end else begin
                        alu_res = sum_ext[WIDTH-1:0];
                    end
                end else if (sum_ext[WIDTH]) begin
                    alu_res  = '1;
                    alu_flag = 1'b1;
                end else begin
                    alu_res = sum_ext[WIDTH-1:0];
                end
            end
            default: alu_flag = 1'b1;
        endcase
    end

    // One shift step; signed SHL flags any change of the MSB across the step
    always_comb begin
        if (shl_q) begin
            step_val  = {work_q[WIDTH-2:0], 1'b0};
            step_flag = sgn_q ? (work_q[WIDTH-1] ^ work_q[WIDTH-2]) : work_q[WIDTH-1];
        end else begin
            step_val  = {sgn_q & work_q[WIDTH-1], work_q[WIDTH-1:1]};
            step_flag = work_q[0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            res_q       <= '0;
            flag_q      <= 1'b0;
            cnt_q       <= '0;
            work_q      <= '0;
            sticky_q    <= 1'b0;
            sgn_q       <= 1'b0;
            shl_q       <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    in_ready_q <= 1'b1;
                    if (in_valid && in_ready_q) begin
                        in_ready_q <= 1'b0;
                        sgn_q      <= in_signed;
                        shl_q      <= (in_op == OP_SHL);
                        work_q     <= in_a;
                        sticky_q   <= 1'b0;
                        if (is_shift && (shamt_clamped != '0)) begin
                            cnt_q   <= shamt_clamped;
                            state_q <= SHIFT;
                        end else begin
                            res_q       <= alu_res;
                            flag_q      <= alu_flag;
                            out_valid_q <= 1'b1;
                            state_q     <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    work_q   <= step_val;
                    sticky_q <= sticky_q | step_flag;
                    if (cnt_q == SH_ONE) begin
                        cnt_q       <= '0;
                        res_q       <= step_val;
                        flag_q      <= sticky_q | step_flag;
                        out_valid_q <= 1'b1;
                        state_q     <= DONE;
                    end else begin
                        cnt_q <= cnt_q - SH_ONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

endmodule
